// File: rtl/gf2m_pkg.sv
// Shared field parameters, types and window helper for the GF(2^M) trinomial reducer.
package gf2m_pkg;

  localparam int unsigned M      = 49;
  localparam int unsigned K      = 9;
  localparam int unsigned FOLD   = 8;
  localparam int unsigned PROD_W = 2 * M - 1;
  localparam int unsigned ITER   = (M - 1 + FOLD - 1) / FOLD;
  localparam int unsigned CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [M-1:0]      elem_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  // Bit mask selecting fold window j: acc[hi_j : lo_j], lo_j clamped at M.
  function automatic prod_t win_mask(input cnt_t j);
    int unsigned hi;
    int unsigned lo;
    hi = PROD_W - 1 - 32'(j) * FOLD;
    lo = (hi >= M + FOLD - 1) ? hi - FOLD + 1 : M;
    return ({PROD_W{1'b1}} << lo) & ({PROD_W{1'b1}} >> (PROD_W - 1 - hi));
  endfunction

endpackage

// File: rtl/gf2m_fold_step.sv
// Combinational fold of one high-order window of the accumulator modulo x^M + x^K + 1.
module gf2m_fold_step
  import gf2m_pkg::*;
(
  input  prod_t i_acc,
  input  cnt_t  i_j,
  output prod_t o_acc_c
);

  prod_t w_win;

  // Each window bit x^i is replaced by x^(i-M) + x^(i-M+K); targets sit below the window.
  always_comb begin
    w_win   = i_acc & win_mask(i_j);
    o_acc_c = i_acc ^ w_win ^ (w_win >> M) ^ (w_win >> (M - K));
  end

endmodule

// File: rtl/gf2m_reduce_seq.sv
// Iterative GF(2^M) reducer: folds FOLD product bits per cycle behind a valid/ready handshake.
// Optional GF_REDUCE_EARLY_EXIT_EN: finish as soon as no bits at or above x^M remain.
module gf2m_reduce_seq
  import gf2m_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  prod_t in_prod,
  output logic  out_valid,
  input  logic  out_ready,
  output elem_t out_elem,
  output logic  busy
);

  state_t r_state;
  state_t w_state_nxt;
  prod_t  r_acc;
  prod_t  w_acc_nxt;
  prod_t  w_acc_fold;
  cnt_t   r_cnt;
  cnt_t   w_cnt_nxt;
  logic   r_in_ready;
  logic   r_out_valid;
  logic   r_busy;
  elem_t  r_out_elem;
`ifdef GF_REDUCE_EARLY_EXIT_EN
  logic   w_hi_zero;

  assign w_hi_zero = (r_acc[PROD_W-1:M] == '0);
`endif

  gf2m_fold_step u_fold (
    .i_acc   (r_acc),
    .i_j     (r_cnt),
    .o_acc_c (w_acc_fold)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_acc_nxt   = in_prod;
          w_cnt_nxt   = '0;
          w_state_nxt = REDUCE;
        end
      end
      REDUCE: begin
`ifdef GF_REDUCE_EARLY_EXIT_EN
        if (w_hi_zero) begin
          w_state_nxt = DONE;
        end else begin
          w_acc_nxt = w_acc_fold;
          if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = DONE;
          else                           w_cnt_nxt   = cnt_t'(r_cnt + 1'b1);
        end
`else
        w_acc_nxt = w_acc_fold;
        if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = DONE;
        else                           w_cnt_nxt   = cnt_t'(r_cnt + 1'b1);
`endif
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_elem  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
      if (r_state != DONE && w_state_nxt == DONE) r_out_elem <= w_acc_nxt[M-1:0];
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_elem  = r_out_elem;

endmodule
